// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants and the hazard controller state encoding.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_IW = 32'h00000013;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} hz_state_t;

endpackage

// File: rtl/rv32i_src_use.sv
// Source-register usage decode for one instruction word; shared with the ID stage.
module rv32i_src_use
  import rv32i_pkg::*;
(
  input  logic [31:0] iw,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  logic [6:0] opcode;
  logic       unused_iw;

  assign opcode    = iw[6:0];
  assign rs1       = iw[19:15];
  assign rs2       = iw[24:20];
  assign unused_iw = ^{iw[31:25], iw[14:7]};

  assign uses_rs1 = opcode inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  assign uses_rs2 = opcode inside {OP_R, OP_STORE, OP_BRANCH};

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Load-use stall / redirect flush sequencer with saturating perf counters.
module rv32i_hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 2,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_iw,
  input  logic [31:0]      ex_iw,
  input  logic             ex_wb_en,
  input  logic [4:0]       ex_wb_reg,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             mem_busy,
  output logic             stall_pc,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic             freeze_all,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] SCNT_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

  hz_state_t  state, state_nxt;
  logic [2:0] scnt, scnt_nxt, fcnt, fcnt_nxt;
  logic       uses_rs1, uses_rs2;
  logic [4:0] rs1, rs2;
  logic       lu_hit, stall_inc, flush_inc;
  logic       unused_ex_iw;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  rv32i_src_use u_src_use (
    .iw       (id_iw),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .rs1      (rs1),
    .rs2      (rs2)
  );

  assign unused_ex_iw = ^ex_iw[31:7];

  // x0 destinations never create a dependency, so they are excluded up front.
  assign lu_hit = (ex_iw[6:0] == OP_LOAD) && ex_wb_en && (ex_wb_reg != 5'd0) &&
                  ((uses_rs1 && (rs1 == ex_wb_reg)) || (uses_rs2 && (rs2 == ex_wb_reg)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      scnt  <= 3'd0;
      fcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    fcnt_nxt  = fcnt;
    if (!mem_busy) begin
      case (state)
        RUN: begin
          if (ex_redirect) begin
            if (FLUSH_CYCLES > 1) begin
              state_nxt = FLUSH;
              fcnt_nxt  = FCNT_INIT;
            end
          end else if (lu_hit && (LOAD_STALL_CYCLES > 1)) begin
            state_nxt = STALL;
            scnt_nxt  = SCNT_INIT;
          end
        end
        STALL: begin
          if (ex_redirect) begin
            scnt_nxt  = 3'd0;
            state_nxt = RUN;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = FLUSH;
              fcnt_nxt  = FCNT_INIT;
            end
          end else begin
            scnt_nxt = scnt - 1'b1;
            if (scnt == 3'd1) state_nxt = RUN;
          end
        end
        FLUSH: begin
          fcnt_nxt = fcnt - 1'b1;
          if (fcnt == 3'd1) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    stall_pc       = 1'b0;
    stall_id       = 1'b0;
    bubble_ex      = 1'b0;
    flush_if_id    = 1'b0;
    freeze_all     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        freeze_all = 1'b1;
      end else if ((state != FLUSH) && ex_redirect) begin
        redirect_valid = 1'b1;
        redirect_pc    = ex_target;
        flush_if_id    = 1'b1;
        bubble_ex      = 1'b1;
        flush_inc      = 1'b1;
      end else if ((state == STALL) || ((state == RUN) && lu_hit)) begin
        stall_pc  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
        stall_inc = 1'b1;
      end else if (state == FLUSH) begin
        flush_if_id = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
      if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Scoreboard bench for rv32i_hazard_ctrl: default build plus a LOAD_STALL=3/FLUSH=4/CNT_W=4 build.
module tb_rv32i_hazard_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] LW  = 32'h0000A283;
  localparam logic [31:0] ADD = 32'h00228333;
  localparam logic [31:0] SB  = 32'h00500023;
  localparam logic [31:0] LUI = 32'h123452B7;

  // ctl = {freeze_all, stall_pc, stall_id, bubble_ex, flush_if_id, redirect_valid}
  localparam logic [5:0] C0      = 6'b000000;
  localparam logic [5:0] C_STALL = 6'b011100;
  localparam logic [5:0] C_RED   = 6'b000111;
  localparam logic [5:0] C_FL    = 6'b000010;
  localparam logic [5:0] C_FRZ   = 6'b100000;

  typedef struct packed {
    logic        b;
    logic [5:0]  ctl;
    logic [31:0] pc;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic        clk, reset;
  logic [31:0] id_iw, ex_iw, ex_target;
  logic        ex_wb_en, ex_redirect, mem_busy;
  logic [4:0]  ex_wb_reg;

  logic        a_stall_pc, a_stall_id, a_bubble, a_flush, a_freeze, a_rv;
  logic [31:0] a_pc, a_sc, a_fc;
  logic        b_stall_pc, b_stall_id, b_bubble, b_flush, b_freeze, b_rv;
  logic [31:0] b_pc;
  logic [3:0]  b_sc, b_fc;

  exp_t q[$];
  exp_t e, o;
  int   total = 0;
  int   bad = 0;

  rv32i_hazard_ctrl dut_a (
    .clk(clk), .reset(reset), .id_iw(id_iw), .ex_iw(ex_iw), .ex_wb_en(ex_wb_en),
    .ex_wb_reg(ex_wb_reg), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .mem_busy(mem_busy), .stall_pc(a_stall_pc), .stall_id(a_stall_id),
    .bubble_ex(a_bubble), .flush_if_id(a_flush), .freeze_all(a_freeze),
    .redirect_valid(a_rv), .redirect_pc(a_pc), .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  rv32i_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .id_iw(id_iw), .ex_iw(ex_iw), .ex_wb_en(ex_wb_en),
    .ex_wb_reg(ex_wb_reg), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .mem_busy(mem_busy), .stall_pc(b_stall_pc), .stall_id(b_stall_id),
    .bubble_ex(b_bubble), .flush_if_id(b_flush), .freeze_all(b_freeze),
    .redirect_valid(b_rv), .redirect_pc(b_pc), .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic b, input logic [5:0] ctl,
                              input logic [31:0] pc, input logic [31:0] sc,
                              input logic [31:0] fc);
    return {b, ctl, pc, sc, fc};
  endfunction

  function automatic exp_t obs(input logic b);
    if (!b)
      return {1'b0, a_freeze, a_stall_pc, a_stall_id, a_bubble, a_flush, a_rv, a_pc, a_sc, a_fc};
    return {1'b1, b_freeze, b_stall_pc, b_stall_id, b_bubble, b_flush, b_rv, b_pc,
            28'd0, b_sc, 28'd0, b_fc};
  endfunction

  task automatic drv(input logic [31:0] id, input logic [31:0] ex, input logic wb,
                     input logic [4:0] rd, input logic redir, input logic [31:0] tgt,
                     input logic busy, input logic rst);
    @(negedge clk);
    id_iw = id; ex_iw = ex; ex_wb_en = wb; ex_wb_reg = rd;
    ex_redirect = redir; ex_target = tgt; mem_busy = busy; reset = rst;
  endtask

  task automatic idle();
    drv(NOP, NOP, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drv(NOP, NOP, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drv(ADD, LW, 1'b1, 5'd5, 1'b1, 32'h100, 1'b1, 1'b1);
      else idle();
      if (i > 0) begin
        q.push_back(mk(1'b0, C0, 32'd0, 32'd0, 32'd0));
        q.push_back(mk(1'b1, C0, 32'd0, 32'd0, 32'd0));
      end
      #1;
      while (q.size() > 0) begin
        e = q.pop_front(); o = obs(e.b); total++;
        if (o !== e) begin
          bad++;
          $display("FAIL reset cyc%0d inst%0d got ctl=%b pc=%h sc=%0d fc=%0d need ctl=%b pc=%h sc=%0d fc=%0d",
                   i, e.b, o.ctl, o.pc, o.sc, o.fc, e.ctl, e.pc, e.sc, e.fc);
        end
      end
    end
  endtask

  task automatic test_load_use_rs1();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drv(ADD, LW, 1'b1, 5'd5, 1'b0, 32'd0, 1'b0, 1'b0);
      else idle();
      q.push_back(mk(1'b0, (i == 0) ? C_STALL : C0, 32'd0, (i == 0) ? 32'd0 : 32'd1, 32'd0));
      q.push_back(mk(1'b1, (i < 3) ? C_STALL : C0, 32'd0, i, 32'd0));
      #1;
      while (q.size() > 0) begin
        e = q.pop_front(); o = obs(e.b); total++;
        if (o !== e) begin
          bad++;
          $display("FAIL load_use_rs1 cyc%0d inst%0d got ctl=%b pc=%h sc=%0d fc=%0d need ctl=%b pc=%h sc=%0d fc=%0d",
                   i, e.b, o.ctl, o.pc, o.sc, o.fc, e.ctl, e.pc, e.sc, e.fc);
        end
      end
    end
  endtask

  task automatic test_store_rs2();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drv(SB, LW, 1'b1, 5'd5, 1'b0, 32'd0, 1'b0, 1'b0);
      else if (i == 2) drv(SB, LW, 1'b1, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      else idle();
      q.push_back(mk(1'b0, (i == 0) ? C_STALL : C0, 32'd0, (i == 0) ? 32'd0 : 32'd1, 32'd0));
      #1;
      while (q.size() > 0) begin
        e = q.pop_front(); o = obs(e.b); total++;
        if (o !== e) begin
          bad++;
          $display("FAIL store_rs2 cyc%0d inst%0d got ctl=%b pc=%h sc=%0d fc=%0d need ctl=%b pc=%h sc=%0d fc=%0d",
                   i, e.b, o.ctl, o.pc, o.sc, o.fc, e.ctl, e.pc, e.sc, e.fc);
        end
      end
    end
  endtask

  task automatic test_non_user();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drv(LUI, LW, 1'b1, 5'd8, 1'b0, 32'd0, 1'b0, 1'b0);
      else idle();
      q.push_back(mk(1'b0, C0, 32'd0, 32'd0, 32'd0));
      q.push_back(mk(1'b1, C0, 32'd0, 32'd0, 32'd0));
      #1;
      while (q.size() > 0) begin
        e = q.pop_front(); o = obs(e.b); total++;
        if (o !== e) begin
          bad++;
          $display("FAIL non_user cyc%0d inst%0d got ctl=%b pc=%h sc=%0d fc=%0d need ctl=%b pc=%h sc=%0d fc=%0d",
                   i, e.b, o.ctl, o.pc, o.sc, o.fc, e.ctl, e.pc, e.sc, e.fc);
        end
      end
    end
  endtask

  task automatic test_redirect_lu();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      // Hazard plus redirect held for two cycles: the second is absorbed by FLUSH.
      if (i < 2) drv(ADD, LW, 1'b1, 5'd5, 1'b1, 32'h100, 1'b0, 1'b0);
      else idle();
      q.push_back(mk(1'b0, (i == 0) ? C_RED : (i == 1) ? C_FL : C0,
                     (i == 0) ? 32'h100 : 32'd0, 32'd0, (i == 0) ? 32'd0 : 32'd1));
      q.push_back(mk(1'b1, (i == 0) ? C_RED : (i < 4) ? C_FL : C0,
                     (i == 0) ? 32'h100 : 32'd0, 32'd0, (i == 0) ? 32'd0 : 32'd1));
      #1;
      while (q.size() > 0) begin
        e = q.pop_front(); o = obs(e.b); total++;
        if (o !== e) begin
          bad++;
          $display("FAIL redirect_lu cyc%0d inst%0d got ctl=%b pc=%h sc=%0d fc=%0d need ctl=%b pc=%h sc=%0d fc=%0d",
                   i, e.b, o.ctl, o.pc, o.sc, o.fc, e.ctl, e.pc, e.sc, e.fc);
        end
      end
    end
  endtask

  task automatic test_busy_mid_stall();
    logic [5:0]  bctl;
    logic [31:0] bsc;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drv(ADD, LW, 1'b1, 5'd5, 1'b0, 32'd0, 1'b0, 1'b0);
      else if (i < 5) drv(ADD, LW, 1'b1, 5'd5, 1'b1, 32'h200, 1'b1, 1'b0);
      else idle();
      bctl = (i == 0 || i == 5 || i == 6) ? C_STALL : (i < 5) ? C_FRZ : C0;
      bsc  = (i == 0) ? 32'd0 : (i < 6) ? 32'd1 : (i == 6) ? 32'd2 : 32'd3;
      q.push_back(mk(1'b0, (i == 0) ? C_STALL : (i < 5) ? C_FRZ : C0, 32'd0,
                     (i == 0) ? 32'd0 : 32'd1, 32'd0));
      q.push_back(mk(1'b1, bctl, 32'd0, bsc, 32'd0));
      #1;
      while (q.size() > 0) begin
        e = q.pop_front(); o = obs(e.b); total++;
        if (o !== e) begin
          bad++;
          $display("FAIL busy_mid_stall cyc%0d inst%0d got ctl=%b pc=%h sc=%0d fc=%0d need ctl=%b pc=%h sc=%0d fc=%0d",
                   i, e.b, o.ctl, o.pc, o.sc, o.fc, e.ctl, e.pc, e.sc, e.fc);
        end
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drv(NOP, NOP, 1'b0, 5'd0, 1'b1, 32'h100, 1'b0, 1'b0);
      else if (i == 1) drv(NOP, NOP, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b1);
      else if (i == 3) drv(ADD, LW, 1'b1, 5'd5, 1'b0, 32'd0, 1'b0, 1'b0);
      else idle();
      q.push_back(mk(1'b1, (i == 0) ? C_RED : (i == 3) ? C_STALL : C0,
                     (i == 0) ? 32'h100 : 32'd0, 32'd0, (i == 1) ? 32'd1 : 32'd0));
      if (i < 2)
        q.push_back(mk(1'b0, (i == 0) ? C_RED : C0, (i == 0) ? 32'h100 : 32'd0,
                       32'd0, (i == 1) ? 32'd1 : 32'd0));
      #1;
      while (q.size() > 0) begin
        e = q.pop_front(); o = obs(e.b); total++;
        if (o !== e) begin
          bad++;
          $display("FAIL reset_mid_flush cyc%0d inst%0d got ctl=%b pc=%h sc=%0d fc=%0d need ctl=%b pc=%h sc=%0d fc=%0d",
                   i, e.b, o.ctl, o.pc, o.sc, o.fc, e.ctl, e.pc, e.sc, e.fc);
        end
      end
    end
  endtask

  task automatic test_saturate();
    logic [31:0] n;
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      for (int j = 0; j < 3; j++) begin
        if (k == 16 && j > 0) break;
        if (k == 16) idle();
        else if (j == 0) drv(ADD, LW, 1'b1, 5'd5, 1'b0, 32'd0, 1'b0, 1'b0);
        else idle();
        n = 32'(3 * k + j);
        q.push_back(mk(1'b1, (k == 16) ? C0 : C_STALL, 32'd0, (n > 32'd15) ? 32'd15 : n, 32'd0));
        #1;
        while (q.size() > 0) begin
          e = q.pop_front(); o = obs(e.b); total++;
          if (o !== e) begin
            bad++;
            $display("FAIL saturate hz%0d cyc%0d got ctl=%b sc=%0d need ctl=%b sc=%0d",
                     k, j, o.ctl, o.sc, e.ctl, e.sc);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; id_iw = NOP; ex_iw = NOP; ex_wb_en = 1'b0; ex_wb_reg = 5'd0;
    ex_redirect = 1'b0; ex_target = 32'd0; mem_busy = 1'b0;
    test_reset();
    test_load_use_rs1();
    test_store_rs2();
    test_non_user();
    test_redirect_lu();
    test_busy_mid_stall();
    test_reset_mid_flush();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
